// File: rtl/register_if.sv
// ---------------------------------------------------------------------------
// register_if
//   Write/read bundle for one datapath register.
//
//   Load/IN form a write strobe. Load is active-high and is sampled only on
//   the rising clock edge. When Load is high at an edge, IN is captured at
//   that same edge. There is no acknowledge and no back-pressure: a write
//   presented at an edge is always taken in that cycle.
//
//   Signals
//     Load  master->slave  1      write enable
//     IN    master->slave  WIDTH  write data
//     OUT   slave->master  WIDTH  current register contents
//
//   Modports
//     master : the writer/reader (datapath control, testbench)
//     slave  : the register itself
// ---------------------------------------------------------------------------
interface register_if #(
    parameter int WIDTH = 32
);
    logic             Load;
    logic [WIDTH-1:0] IN;
    logic [WIDTH-1:0] OUT;

    modport master (
        output Load,
        output IN,
        input  OUT
    );

    modport slave (
        input  Load,
        input  IN,
        output OUT
    );
endinterface

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//   Load-enabled data register for the CPU datapath. Sixteen of these share
//   one IN bus, each with its own Load bit, to form the register file; OUT
//   feeds the register-file read multiplexers directly.
//
//   Parameters
//     WIDTH        data width in bits (must match the bus interface WIDTH)
//     RESET_VALUE  value OUT takes while Reset is low
//
//   Ports
//     Clk    input   clock, all captures on the rising edge
//     Reset  input   asynchronous, active-low reset
//     bus    slave   Load / IN / OUT bundle (see register_if)
//
//   OUT comes straight from the flops: there is no combinational path from
//   IN or Load, so OUT only moves at a rising Clk edge or on Reset falling.
//   Reset is in the sensitivity list, so it overrides any edge that lands in
//   the same instant.
// ---------------------------------------------------------------------------
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic        Clk,
    input  logic        Reset,
    register_if.slave   bus
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus.OUT <= RESET_VALUE;
        end else if (bus.Load) begin
            bus.OUT <= bus.IN;
        end
    end

endmodule

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register
//   Directed bench for register: a main 32-bit instance, a 16-entry bank
//   sharing one IN bus, and a small 8-bit instance with a non-zero reset
//   value.
// ---------------------------------------------------------------------------
module tb_register;

    // ---------------- clock / reset ----------------
    logic Clk;
    logic Reset;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- main instance ----------------
    register_if #(.WIDTH(32)) dut_if ();

    register #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (dut_if.slave)
    );

    // ---------------- 16-entry bank, shared IN ----------------
    logic [15:0] bank_load;
    logic [31:0] bank_in;
    logic [31:0] bank_out [16];

    for (genvar g = 0; g < 16; g++) begin : g_bank
        register_if #(.WIDTH(32)) bank_if ();
        assign bank_if.Load = bank_load[g];
        assign bank_if.IN   = bank_in;
        assign bank_out[g]  = bank_if.OUT;

        register #(.WIDTH(32), .RESET_VALUE(32'h0)) u_reg (
            .Clk   (Clk),
            .Reset (Reset),
            .bus   (bank_if.slave)
        );
    end

    // ---------------- 8-bit instance, reset value A5 ----------------
    register_if #(.WIDTH(8)) small_if ();

    register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_small (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (small_if.slave)
    );

    // ---------------- scoreboard counters / checker ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive main-instance write inputs at the falling edge, away from capture.
    task automatic drive(input logic ld, input logic [31:0] d);
        @(negedge Clk);
        dut_if.Load = ld;
        dut_if.IN   = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset         = 1'b0;
        dut_if.Load   = 1'b1;
        dut_if.IN     = 32'd5;
        bank_load     = '0;
        bank_in       = 32'd0;
        small_if.Load = 1'b1;
        small_if.IN   = 8'h3C;

        // Reset held low with clock running and Load=1: outputs pinned.
        repeat (3) tick();
        check("rst_hold_main", dut_if.OUT, 32'h0);
        check("rst_hold_small", {24'h0, small_if.OUT}, 32'h0000_00A5);
        check("rst_hold_bank0", bank_out[0], 32'h0);

        // Release reset at the falling edge with Load low: no change.
        @(negedge Clk);
        dut_if.Load   = 1'b0;
        small_if.Load = 1'b0;
        Reset         = 1'b1;
        #1;
        check("rst_release", dut_if.OUT, 32'h0);
        tick();
        check("no_load_after_rst", dut_if.OUT, 32'h0);
        check("small_after_rst", {24'h0, small_if.OUT}, 32'h0000_00A5);

        // First load.
        drive(1'b1, 32'd1);
        tick();
        check("load_1", dut_if.OUT, 32'd1);

        // Hold for 10 edges with different IN.
        drive(1'b0, 32'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold_%0d", i), dut_if.OUT, 32'd1);
        end

        // Small instance loads its full 8 bits.
        @(negedge Clk);
        small_if.Load = 1'b1;
        tick();
        check("small_load", {24'h0, small_if.OUT}, 32'h0000_003C);
        small_if.Load = 1'b0;

        // IN changes mid-cycle; only the value at the rising edge counts.
        drive(1'b1, 32'h0000_1234);
        #2;
        dut_if.IN = 32'h0000_ABCD;
        tick();
        check("mid_cycle_cap", dut_if.OUT, 32'h0000_ABCD);
        dut_if.IN = 32'h0000_1234;
        @(negedge Clk);
        #1;
        check("no_fall_cap", dut_if.OUT, 32'h0000_ABCD);
        dut_if.Load = 1'b0;

        // Full-width values.
        drive(1'b1, 32'hFFFF_FFFF);
        tick();
        check("full_ones", dut_if.OUT, 32'hFFFF_FFFF);
        drive(1'b1, 32'h8000_0001);
        tick();
        check("msb_lsb", dut_if.OUT, 32'h8000_0001);

        // 16-entry bank: cycle k loads register k with k+1.
        dut_if.Load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            bank_load = 16'(1 << k);
            bank_in   = 32'(k + 1);
            tick();
            check($sformatf("bank_wr_%0d", k), bank_out[k], 32'(k + 1));
        end
        @(negedge Clk);
        bank_load = '0;
        bank_in   = 32'hDEAD_BEEF;
        repeat (4) tick();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("bank_keep_%0d", k), bank_out[k], 32'(k + 1));
        end

        // Async reset between edges: OUT clears before any edge.
        drive(1'b1, 32'hFFFF_FFFF);
        tick();
        check("pre_async", dut_if.OUT, 32'hFFFF_FFFF);
        dut_if.Load = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check("async_clear", dut_if.OUT, 32'h0);
        check("async_small", {24'h0, small_if.OUT}, 32'h0000_00A5);
        dut_if.Load = 1'b1;
        repeat (2) tick();
        check("load_in_rst", dut_if.OUT, 32'h0);
        @(negedge Clk);
        dut_if.Load = 1'b0;
        Reset = 1'b1;
        tick();
        check("after_async", dut_if.OUT, 32'h0);

        // Reset asserted at the same instant as a loading edge.
        drive(1'b1, 32'h0000_0077);
        tick();
        check("pre_coincide", dut_if.OUT, 32'h0000_0077);
        dut_if.IN = 32'h0000_0099;
        @(posedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_wins", dut_if.OUT, 32'h0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
